// File: rtl/usb_rx_nrzi_decoder.sv
// USB RX line decoder: pin synchroniser, J/K/SE0/SE1 classification,
// NRZI decode, bit unstuffing, EOP qualification and packet tracking.
module usb_rx_nrzi_decoder #(
    parameter int SYNC_STAGES  = 2,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic sample_en,
    output logic rx_bit,
    output logic rx_bit_valid,
    output logic eop,
    output logic stuff_err,
    output logic line_err,
    output logic rx_active
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EOP_SE0
    } state_t;

    // Line states as {D+, D-}
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    localparam logic [CNT_W-1:0] STUFF_C = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] EOP_C   = CNT_W'(EOP_SE0_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] dp_q;
    logic [SYNC_STAGES-1:0] dm_q;
    logic [1:0]             line_d;
    logic                   nrzi_d;

    state_t                 state_q;
    logic [1:0]             prev_q;
    logic [CNT_W-1:0]       ones_q;
    logic [CNT_W-1:0]       se0_q;

    // Metastability chain on both pins; idles at J
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_q <= '1;
            dm_q <= '0;
        end else begin
            dp_q[0] <= d_plus;
            dm_q[0] <= d_minus;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dp_q[i] <= dp_q[i-1];
                dm_q[i] <= dm_q[i-1];
            end
        end
    end

    assign line_d = {dp_q[SYNC_STAGES-1], dm_q[SYNC_STAGES-1]};
    assign nrzi_d = (line_d == prev_q);

    // Packet FSM: decode, unstuff, qualify EOP; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= LS_J;
            ones_q       <= '0;
            se0_q        <= '0;
            rx_bit       <= 1'b0;
            rx_bit_valid <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
            line_err     <= 1'b0;
            rx_active    <= 1'b0;
        end else begin
            rx_bit_valid <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
            line_err     <= 1'b0;
            if (sample_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (line_d == LS_K) begin
                            rx_bit       <= 1'b0;
                            rx_bit_valid <= 1'b1;
                            prev_q       <= LS_K;
                            ones_q       <= '0;
                            state_q      <= ACTIVE;
                            rx_active    <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        unique case (line_d)
                            LS_J, LS_K: begin
                                prev_q <= line_d;
                                if (ones_q == STUFF_C) begin
                                    // Stuff bit: dropped, must be a 0
                                    ones_q    <= '0;
                                    stuff_err <= nrzi_d;
                                end else begin
                                    rx_bit       <= nrzi_d;
                                    rx_bit_valid <= 1'b1;
                                    ones_q       <= nrzi_d ? ones_q + CNT_ONE : '0;
                                end
                            end
                            LS_SE0: begin
                                se0_q   <= CNT_ONE;
                                state_q <= EOP_SE0;
                            end
                            default: begin
                                // SE1 sample is discarded, prev line kept
                                line_err <= 1'b1;
                            end
                        endcase
                    end
                    EOP_SE0: begin
                        if (line_d == LS_SE0) begin
                            if (se0_q != CNT_MAX) begin
                                se0_q <= se0_q + CNT_ONE;
                            end
                        end else begin
                            if (line_d == LS_J && se0_q >= EOP_C) begin
                                eop <= 1'b1;
                            end else begin
                                line_err <= 1'b1;
                            end
                            state_q   <= IDLE;
                            prev_q    <= LS_J;
                            ones_q    <= '0;
                            se0_q     <= '0;
                            rx_active <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
